// File: rtl/twiddle_sched_pkg.sv
// Shared types for the twiddle multiplier scheduler: FSM state codes, operand part and tag record.
// The optional pre-adder is selected by the SCHED_ROTATE_EN macro in twiddle_mul_sched.sv.
package twiddle_sched_pkg;

   localparam int unsigned MAX_ID_W = 3;

   typedef logic [0:0] state_t;
   localparam state_t IDLE     = 1'b0;
   localparam state_t ISSUE_IM = 1'b1;

   typedef enum logic {
      PART_RE = 1'b0,
      PART_IM = 1'b1
   } part_e;

   typedef struct packed {
      logic                valid;
      part_e               part;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

   function automatic int unsigned id_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/twiddle_mul_sched_if.sv
// Requester, multiplier and response signals of the twiddle multiplier scheduler.
interface twiddle_mul_sched_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REQ    = 2
) ();
   import twiddle_sched_pkg::*;

   localparam int unsigned ID_W = id_w(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_re;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_im;
   logic [NUM_REQ-1:0]            req_rot;
   logic [DATA_WIDTH-1:0]         mult_data;
   logic [DATA_WIDTH-1:0]         mult_result;
   logic                          rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_re;
   logic [DATA_WIDTH-1:0]         rsp_im;
   logic [ID_W-1:0]               rsp_id;
   logic                          busy;

   modport master (
      output req_valid, req_re, req_im, req_rot, mult_result,
      input  req_ready, mult_data, rsp_valid, rsp_re, rsp_im, rsp_id, busy
   );

   modport slave (
      input  req_valid, req_re, req_im, req_rot, mult_result,
      output req_ready, mult_data, rsp_valid, rsp_re, rsp_im, rsp_id, busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant; pointer moves only when a grant is taken.
module rr_arbiter
   import twiddle_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [NUM_REQ-1:0]        req,
   output logic [NUM_REQ-1:0]        grant_c,
   output logic [id_w(NUM_REQ)-1:0]  grant_idx_c,
   output logic                      grant_valid_c
);

   localparam int unsigned ID_W = id_w(NUM_REQ);

   logic [ID_W-1:0] last_q;
   logic [ID_W-1:0] k_c;

   // First active requester after last_q, wrapping around.
   always_comb begin
      grant_c       = '0;
      grant_idx_c   = '0;
      grant_valid_c = 1'b0;
      k_c           = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k_c = ID_W'((32'(last_q) + 32'd1 + i) % NUM_REQ);
         if (!grant_valid_c && req[k_c]) begin
            grant_valid_c  = 1'b1;
            grant_c[k_c]   = 1'b1;
            grant_idx_c    = k_c;
         end
      end
      if (!en) begin
         grant_c       = '0;
         grant_valid_c = 1'b0;
      end
   end

   // Reset to the last index so requester 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= ID_W'(NUM_REQ - 1);
      end else if (grant_valid_c) begin
         last_q <= grant_idx_c;
      end
   end

endmodule

// File: rtl/twiddle_mul_sched.sv
// Shares one pipelined 0.707 multiplier among NUM_REQ requesters, re-pairing RE/IM products by tag.
// Optional feature macro: SCHED_ROTATE_EN (pre-adder for 0.707*(1-j) rotation).
module twiddle_mul_sched
   import twiddle_sched_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned MULT_LATENCY = 3
) (
   input  logic               clk,
   input  logic               rst,
   twiddle_mul_sched_if.slave bus
);

   localparam int unsigned ID_W = id_w(NUM_REQ);

   state_t                  state_q;
   state_t                  state_n;
   logic [NUM_REQ-1:0]      grant_c;
   logic [ID_W-1:0]         grant_idx_c;
   logic                    grant_valid_c;
   logic [ID_W-1:0]         gid_q;
   logic [DATA_WIDTH-1:0]   sel_re_c;
   logic [DATA_WIDTH-1:0]   sel_im_c;
   logic [DATA_WIDTH-1:0]   op_a_c;
   logic [DATA_WIDTH-1:0]   op_b_c;
   logic [DATA_WIDTH-1:0]   im_hold_q;
   logic [DATA_WIDTH-1:0]   re_hold_q;
   tag_t                    tag_in_c;
   tag_t                    tag_q [MULT_LATENCY];
   tag_t                    tail_c;
   logic                    tags_busy_n_c;
   logic                    unused_id_c;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk           (clk),
      .rst           (rst),
      .en            (state_q == IDLE),
      .req           (bus.req_valid),
      .grant_c       (grant_c),
      .grant_idx_c   (grant_idx_c),
      .grant_valid_c (grant_valid_c)
   );

   // Operand selection from the granted requester.
   always_comb begin
      sel_re_c = bus.req_re[32'(grant_idx_c)*DATA_WIDTH +: DATA_WIDTH];
      sel_im_c = bus.req_im[32'(grant_idx_c)*DATA_WIDTH +: DATA_WIDTH];
   end

`ifdef SCHED_ROTATE_EN
   logic sel_rot_c;
   always_comb begin
      sel_rot_c = bus.req_rot[grant_idx_c];
      op_a_c    = sel_rot_c ? (sel_re_c + sel_im_c) : sel_re_c;
      op_b_c    = sel_rot_c ? (sel_im_c - sel_re_c) : sel_im_c;
   end
`else
   logic unused_rot_c;
   assign unused_rot_c = ^bus.req_rot;
   always_comb begin
      op_a_c = sel_re_c;
      op_b_c = sel_im_c;
   end
`endif

   // Issue FSM: RE operand on accept, IM operand on the following cycle.
   always_comb begin
      state_n       = state_q;
      bus.req_ready = '0;
      bus.mult_data = '0;
      tag_in_c      = '0;
      case (state_q)
         IDLE: begin
            if (grant_valid_c) begin
               bus.req_ready = grant_c;
               bus.mult_data = op_a_c;
               tag_in_c      = '{valid: 1'b1, part: PART_RE, id: MAX_ID_W'(grant_idx_c)};
               state_n       = ISSUE_IM;
            end
         end
         ISSUE_IM: begin
            bus.mult_data = im_hold_q;
            tag_in_c      = '{valid: 1'b1, part: PART_IM, id: MAX_ID_W'(gid_q)};
            state_n       = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      tail_c        = tag_q[MULT_LATENCY-1];
      tags_busy_n_c = tag_in_c.valid;
      for (int i = 0; i < int'(MULT_LATENCY) - 1; i++) begin
         tags_busy_n_c = tags_busy_n_c | tag_q[i].valid;
      end
   end

   assign unused_id_c = ^tail_c.id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         im_hold_q <= '0;
         gid_q     <= '0;
         bus.busy  <= 1'b0;
      end else begin
         state_q  <= state_n;
         bus.busy <= (state_n == ISSUE_IM) | tags_busy_n_c;
         if (state_q == IDLE && grant_valid_c) begin
            im_hold_q <= op_b_c;
            gid_q     <= grant_idx_c;
         end
      end
   end

   // Tag pipe mirrors the multiplier latency; IM tail completes the pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(MULT_LATENCY); i++) begin
            tag_q[i] <= '0;
         end
         re_hold_q     <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_re    <= '0;
         bus.rsp_im    <= '0;
         bus.rsp_id    <= '0;
      end else begin
         tag_q[0] <= tag_in_c;
         for (int i = 1; i < int'(MULT_LATENCY); i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         if (tail_c.valid && tail_c.part == PART_RE) begin
            re_hold_q <= bus.mult_result;
         end
         if (tail_c.valid && tail_c.part == PART_IM) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_re    <= re_hold_q;
            bus.rsp_im    <= bus.mult_result;
            bus.rsp_id    <= ID_W'(tail_c.id);
         end else begin
            bus.rsp_valid <= 1'b0;
         end
      end
   end

endmodule
